// File: rtl/if_id_register.sv
// IF/ID pipeline register for the 5-stage MIPS core: load-use hazard detection,
// branch/jump flush, interrupt deferral across bubbles and a saturating stall counter.
module if_id_register #(
    parameter logic [31:0] RESET_PC4 = 32'h80000004,
    parameter logic [31:0] NOP_INSTR = 32'h00000000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      iPC_plus_4,
    input  logic [31:0]      iInstruction,
    input  logic             iInterrupt,
    input  logic             iFlush,
    input  logic             iIDEX_MemRead,
    input  logic [4:0]       iIDEX_Rt,
    output logic [31:0]      oPC_plus_4,
    output logic [31:0]      oInstruction,
    output logic             oInterrupt,
    output logic             oValid,
    output logic             oPCWrite,
    output logic             oStall,
    output logic [CNT_W-1:0] oStallCount
);

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       rs_hit;
    logic       rt_hit;
    logic       pending;
    logic       int_in;
    logic       user_slot;

    assign op = oInstruction[31:26];
    assign rs = oInstruction[25:21];
    assign rt = oInstruction[20:16];

    // R-type, beq, bne and sw read rt as a source; everything else only reads rs.
    always_comb begin
        uses_rt = 1'b0;
        case (op)
            6'h00, 6'h04, 6'h05, 6'h2b: uses_rt = 1'b1;
            default:                    uses_rt = 1'b0;
        endcase
    end

    assign rs_hit   = (iIDEX_Rt == rs);
    assign rt_hit   = uses_rt & (iIDEX_Rt == rt);
    assign oStall   = oValid & iIDEX_MemRead & (iIDEX_Rt != 5'd0) & (rs_hit | rt_hit);
    assign oPCWrite = ~oStall | iFlush;

    // Kernel-mode slots neither carry nor consume an interrupt.
    assign user_slot = ~iPC_plus_4[31];
    assign int_in    = (iInterrupt | pending) & user_slot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oPC_plus_4   <= RESET_PC4;
            oInstruction <= NOP_INSTR;
            oInterrupt   <= 1'b0;
            oValid       <= 1'b0;
            pending      <= 1'b0;
        end else if (iFlush) begin
            // PC+4 is left alone so the bubble still reports a sensible return address.
            oInstruction <= NOP_INSTR;
            oInterrupt   <= 1'b0;
            oValid       <= 1'b0;
            if (int_in) pending <= 1'b1;
        end else if (oStall) begin
            if (int_in) pending <= 1'b1;
        end else begin
            oPC_plus_4   <= iPC_plus_4;
            oInstruction <= iInstruction;
            oInterrupt   <= int_in;
            oValid       <= 1'b1;
            if (user_slot) pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oStallCount <= '0;
        end else if (oStall && (oStallCount != {CNT_W{1'b1}})) begin
            oStallCount <= oStallCount + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_if_id_register.sv
// Self-checking bench for if_id_register: directed vectors, a per-cycle reference
// model compared on every falling edge, and hand-computed literal checks.
module tb_if_id_register;

    localparam logic [31:0] RESET_PC4 = 32'h80000004;
    localparam logic [31:0] ADD_I     = 32'h00221820;  // add $3,$1,$2
    localparam logic [31:0] LW_I      = 32'h8c220000;  // lw  $2,0($1)
    localparam logic [31:0] BEQ_I     = 32'h10220003;  // beq $1,$2,+3
    localparam logic [31:0] ORI_I     = 32'h34240005;  // ori $4,$1,5

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc4_in = '0;
    logic [31:0] instr_in = '0;
    logic        int_in = 1'b0;
    logic        flush = 1'b0;
    logic        mem_read = 1'b0;
    logic [4:0]  ex_rt = '0;

    logic [31:0] pc4_out;
    logic [31:0] instr_out;
    logic        int_out;
    logic        valid;
    logic        pc_write;
    logic        stall;
    logic [15:0] stall_count;

    int errors = 0;
    int checks = 0;

    if_id_register dut (
        .clk           (clk),
        .reset         (reset),
        .iPC_plus_4    (pc4_in),
        .iInstruction  (instr_in),
        .iInterrupt    (int_in),
        .iFlush        (flush),
        .iIDEX_MemRead (mem_read),
        .iIDEX_Rt      (ex_rt),
        .oPC_plus_4    (pc4_out),
        .oInstruction  (instr_out),
        .oInterrupt    (int_out),
        .oValid        (valid),
        .oPCWrite      (pc_write),
        .oStall        (stall),
        .oStallCount   (stall_count)
    );

    always #5 clk = ~clk;

    // Reference model: architectural view of the ID slot.
    logic [31:0] m_pc4;
    logic [31:0] m_instr;
    logic        m_int;
    logic        m_valid;
    logic        m_pending;
    logic [15:0] m_cnt;

    function automatic logic reads_source(input logic [31:0] ins, input logic [4:0] r);
        logic [5:0] opc;
        logic       rt_src;
        opc    = ins[31:26];
        rt_src = (opc == 6'h00) || (opc == 6'h04) || (opc == 6'h05) || (opc == 6'h2b);
        return (r != 5'd0) && ((ins[25:21] == r) || (rt_src && ins[20:16] == r));
    endfunction

    function automatic logic model_stall();
        return m_valid && mem_read && reads_source(m_instr, ex_rt);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc4 = RESET_PC4; m_instr = '0; m_int = 0; m_valid = 0; m_pending = 0; m_cnt = '0;
        end else begin
            automatic logic st   = model_stall();
            automatic logic user = !pc4_in[31];
            automatic logic irq  = (int_in || m_pending) && user;
            if (st && m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
            if (flush) begin
                m_instr = '0; m_valid = 0; m_int = 0;
                if (irq) m_pending = 1;
            end else if (st) begin
                if (irq) m_pending = 1;
            end else begin
                m_pc4 = pc4_in; m_instr = instr_in; m_valid = 1; m_int = irq;
                if (user) m_pending = 0;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check_output("model pc4",      pc4_out,           m_pc4);
            check_output("model instr",    instr_out,         m_instr);
            check_output("model int",      32'(int_out),      32'(m_int));
            check_output("model valid",    32'(valid),        32'(m_valid));
            check_output("model stall",    32'(stall),        32'(model_stall()));
            check_output("model pc_write", 32'(pc_write),     32'(!model_stall() || flush));
            check_output("model count",    32'(stall_count),  32'(m_cnt));
        end
    end

    task automatic apply_stimulus(input logic [31:0] pc4, input logic [31:0] ins, input logic irq,
                                  input logic fl, input logic mr, input logic [4:0] rt);
        pc4_in = pc4; instr_in = ins; int_in = irq; flush = fl; mem_read = mr; ex_rt = rt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, " valid"}, 32'(valid), 32'd0);
        check_output({tag, " instr"}, instr_out, 32'h0);
        check_output({tag, " pc4"}, pc4_out, 32'h80000004);
        check_output({tag, " pc_write"}, 32'(pc_write), 32'd1);
        check_output({tag, " count"}, 32'(stall_count), 32'd0);
        check_output({tag, " int"}, 32'(int_out), 32'd0);
    endtask

    initial begin
        // Reset pulse spanning an edge.
        reset = 1'b1;
        #12;
        check_reset_values("reset held");
        reset = 1'b0;
        #1;
        check_reset_values("after reset");

        // Load-use hazard on rs stalls for exactly one edge.
        apply_stimulus(32'h4, ADD_I, 0, 0, 0, 5'd0);
        tick();
        check_output("add loaded", instr_out, ADD_I);
        apply_stimulus(32'h8, LW_I, 0, 0, 1, 5'd1);
        check_output("rs hazard stall", 32'(stall), 32'd1);
        check_output("rs hazard pc_write", 32'(pc_write), 32'd0);
        tick();
        check_output("stall holds instr", instr_out, ADD_I);
        check_output("stall holds pc4", pc4_out, 32'h4);
        check_output("stall count 1", 32'(stall_count), 32'd1);

        // Rt=0 never stalls; rt match stalls R-type but not lw.
        apply_stimulus(32'h8, LW_I, 0, 0, 1, 5'd0);
        check_output("rt zero no stall", 32'(stall), 32'd0);
        apply_stimulus(32'h8, LW_I, 0, 0, 1, 5'd2);
        check_output("add rt hazard", 32'(stall), 32'd1);
        apply_stimulus(32'h8, LW_I, 0, 0, 0, 5'd0);
        tick();
        check_output("lw loaded", instr_out, LW_I);
        apply_stimulus(32'hc, BEQ_I, 0, 0, 1, 5'd2);
        check_output("lw rt no stall", 32'(stall), 32'd0);
        tick();
        check_output("beq loaded", instr_out, BEQ_I);
        apply_stimulus(32'h10, ORI_I, 0, 0, 1, 5'd2);
        check_output("beq rt stall", 32'(stall), 32'd1);
        apply_stimulus(32'h10, ORI_I, 0, 0, 0, 5'd0);
        tick();
        apply_stimulus(32'h14, ADD_I, 0, 0, 1, 5'd4);
        check_output("ori rt no stall", 32'(stall), 32'd0);

        // Flush with an interrupt: bubble, then interrupt on the next load.
        apply_stimulus(32'h10, ADD_I, 1, 1, 0, 5'd0);
        tick();
        check_output("flush valid", 32'(valid), 32'd0);
        check_output("flush int", 32'(int_out), 32'd0);
        check_output("flush instr", instr_out, 32'h0);
        check_output("flush pc4 holds", pc4_out, 32'h10);
        apply_stimulus(32'h14, ADD_I, 0, 0, 0, 5'd0);
        tick();
        check_output("deferred int", 32'(int_out), 32'd1);
        check_output("deferred valid", 32'(valid), 32'd1);

        // Kernel-mode fetch ignores the interrupt; nothing pending afterwards.
        apply_stimulus(32'h80000104, ORI_I, 1, 0, 0, 5'd0);
        tick();
        check_output("kernel int", 32'(int_out), 32'd0);
        apply_stimulus(32'h18, ORI_I, 0, 0, 0, 5'd0);
        tick();
        check_output("no pending int", 32'(int_out), 32'd0);

        // Interrupt arriving on a stall edge survives a kernel slot.
        apply_stimulus(32'h1c, ADD_I, 0, 0, 0, 5'd0);
        tick();
        apply_stimulus(32'h20, ORI_I, 1, 0, 1, 5'd1);
        tick();
        check_output("stall int held", 32'(int_out), 32'd0);
        apply_stimulus(32'h80000108, ORI_I, 0, 0, 0, 5'd0);
        tick();
        check_output("kernel keeps pending", 32'(int_out), 32'd0);
        apply_stimulus(32'h24, ORI_I, 0, 0, 0, 5'd0);
        tick();
        check_output("pending delivered", 32'(int_out), 32'd1);

        // Saturation of the stall counter.
        apply_stimulus(32'h28, ADD_I, 0, 0, 0, 5'd0);
        tick();
        apply_stimulus(32'h2c, ORI_I, 0, 0, 1, 5'd1);
        repeat (65539) tick();
        check_output("count saturated", 32'(stall_count), 32'h0000ffff);
        check_output("still stalled", 32'(stall), 32'd1);

        // Asynchronous reset mid-stall takes effect without a clock edge.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_reset_values("async reset");
        apply_stimulus(32'h30, ADD_I, 0, 0, 0, 5'd0);
        #4;
        reset = 1'b0;
        tick();
        check_output("load after reset", instr_out, ADD_I);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
